// File: rtl/hlsm_param_dp_if.sv
// Handshake and data bundle for hlsm_param_dp.
// The requester drives start and the operands and observes the results and status.
interface hlsm_param_dp_if #(
    parameter int DATA_W = 16,
    parameter int Z_W    = 8,
    parameter int X_W    = 16
) ();

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [Z_W-1:0]    z;
    logic [X_W-1:0]    x;
    logic              done;
    logic              busy;

    // Requester side: issues operations, receives results.
    modport master (
        output start, a, b, c,
        input  z, x, done, busy
    );

    // Datapath side: accepts operations, returns results.
    modport slave (
        input  start, a, b, c,
        output z, x, done, busy
    );

endinterface

// File: rtl/hlsm_param_dp.sv
// hlsm_param_dp: scheduled multi-cycle datapath.
// Captures a, b, c on an accepted start, then computes
//   d = a + b, e = a + c, f = a * c, z = max(d, e), x = f - d
// over the sequence IDLE -> ADD -> MUL -> OUT -> DONE. A start seen in DONE
// chains straight into the next ADD, so a held start gives one result per
// 3 + MUL_CYCLES cycles. SIGNED selects two's-complement arithmetic/compare.
module hlsm_param_dp #(
    parameter int DATA_W     = 16,
    parameter int Z_W        = 8,
    parameter int X_W        = 16,
    parameter int SIGNED     = 0,
    parameter int MUL_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    hlsm_param_dp_if.slave bus
);

    localparam int P_W   = 2 * DATA_W;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_MUL  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              mul_last;
    logic [CNT_W-1:0]  cnt_q;

    // Stage registers: p0 = captured operands, p1 = sums, p2 = product.
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [DATA_W-1:0] c_p0;
    logic [DATA_W-1:0] d_p1;
    logic [DATA_W-1:0] e_p1;
    logic [P_W-1:0]    f_p2;

    logic [Z_W-1:0]    z_q;
    logic [X_W-1:0]    x_q;
    logic              done_q;
    logic              busy_q;

    // Widen a DATA_W value to product width, sign- or zero-filled by mode.
    function automatic logic [P_W-1:0] ext_w(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) begin
            return {{DATA_W{v[DATA_W-1]}}, v};
        end
        return {{DATA_W{1'b0}}, v};
    endfunction

    // Full-width product; multiplying the extended operands modulo 2^P_W
    // yields the correct two's-complement product in signed mode.
    function automatic logic [P_W-1:0] mul_full(input logic [DATA_W-1:0] p,
                                                input logic [DATA_W-1:0] q);
        logic signed [P_W-1:0] px;
        logic signed [P_W-1:0] qx;
        px = $signed(ext_w(p));
        qx = $signed(ext_w(q));
        return px * qx;
    endfunction

    // Magnitude compare p > q in the selected number system.
    function automatic logic gt(input logic [DATA_W-1:0] p,
                                input logic [DATA_W-1:0] q);
        logic signed [DATA_W-1:0] ps;
        logic signed [DATA_W-1:0] qs;
        ps = $signed(p);
        qs = $signed(q);
        if (SIGNED != 0) begin
            return ps > qs;
        end
        return p > q;
    endfunction

    // Result narrowing: plain truncation to the low bits (wrap, no saturation).
    function automatic logic [Z_W-1:0] trunc_z(input logic [DATA_W-1:0] v);
        return v[Z_W-1:0];
    endfunction

    function automatic logic [X_W-1:0] trunc_x(input logic [P_W-1:0] v);
        return v[X_W-1:0];
    endfunction

    // Next-state decode; start is only honoured in IDLE and DONE.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        mul_last = (cnt_q == '0);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_MUL;
            end
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d == S_ADD) || (state_d == S_MUL) || (state_d == S_OUT);
        end
    end

    // Multiply-latency counter: loaded in ADD, counts down through MUL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == S_ADD) begin
            cnt_q <= CNT_W'(MUL_CYCLES - 1);
        end else if (state_q == S_MUL && !mul_last) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Scheduled datapath: capture, add, multiply, then form z and x.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_p0 <= '0;
            b_p0 <= '0;
            c_p0 <= '0;
            d_p1 <= '0;
            e_p1 <= '0;
            f_p2 <= '0;
            z_q  <= '0;
            x_q  <= '0;
        end else begin
            if (accept) begin
                a_p0 <= bus.a;
                b_p0 <= bus.b;
                c_p0 <= bus.c;
            end
            if (state_q == S_ADD) begin
                d_p1 <= a_p0 + b_p0;
                e_p1 <= a_p0 + c_p0;
            end
            if (state_q == S_MUL && mul_last) begin
                f_p2 <= mul_full(a_p0, c_p0);
            end
            if (state_q == S_OUT) begin
                z_q <= trunc_z(gt(d_p1, e_p1) ? d_p1 : e_p1);
                x_q <= trunc_x(f_p2 - ext_w(d_p1));
            end
        end
    end

    assign bus.z    = z_q;
    assign bus.x    = x_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_hlsm_param_dp.sv
// Bench for hlsm_param_dp: three instances (unsigned/1-cycle multiply,
// signed/1-cycle multiply, unsigned/3-cycle multiply) driven with directed
// vectors; expected results are queued at issue and checked by a monitor
// whenever an instance raises done.
module tb_hlsm_param_dp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hlsm_param_dp_if #(.DATA_W(16), .Z_W(8), .X_W(16)) bus0 ();
    hlsm_param_dp_if #(.DATA_W(16), .Z_W(8), .X_W(16)) bus1 ();
    hlsm_param_dp_if #(.DATA_W(16), .Z_W(8), .X_W(16)) bus2 ();

    hlsm_param_dp #(.DATA_W(16), .Z_W(8), .X_W(16), .SIGNED(0), .MUL_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .bus(bus0));
    hlsm_param_dp #(.DATA_W(16), .Z_W(8), .X_W(16), .SIGNED(1), .MUL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1));
    hlsm_param_dp #(.DATA_W(16), .Z_W(8), .X_W(16), .SIGNED(0), .MUL_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        int          u;
        logic [7:0]  z;
        logic [15:0] x;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    logic        done_w [3];
    logic        busy_w [3];
    logic [7:0]  z_w    [3];
    logic [15:0] x_w    [3];

    always_comb begin
        done_w[0] = bus0.done; busy_w[0] = bus0.busy; z_w[0] = bus0.z; x_w[0] = bus0.x;
        done_w[1] = bus1.done; busy_w[1] = bus1.busy; z_w[1] = bus1.z; x_w[1] = bus1.x;
        done_w[2] = bus2.done; busy_w[2] = bus2.busy; z_w[2] = bus2.z; x_w[2] = bus2.x;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic set_in(input int u, input logic s,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        case (u)
            0: begin bus0.start = s; bus0.a = a; bus0.b = b; bus0.c = c; end
            1: begin bus1.start = s; bus1.a = a; bus1.b = b; bus1.c = c; end
            default: begin bus2.start = s; bus2.a = a; bus2.b = b; bus2.c = c; end
        endcase
    endtask

    task automatic push_exp(input int u, input logic [7:0] z, input logic [15:0] x, input string nm);
        exp_t e;
        e.u = u; e.z = z; e.x = x; e.name = nm;
        sbq.push_back(e);
    endtask

    // Single operation with a one-cycle start pulse; checks done latency and width.
    task automatic run_op(input int u, input int mulc, input string nm,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [7:0] ez, input logic [15:0] ex);
        int lat;
        @(negedge clk);
        push_exp(u, ez, ex, nm);
        set_in(u, 1'b1, a, b, c);
        @(posedge clk);
        #1;
        check({nm, "_busy_after_accept"}, 32'(busy_w[u]), 32'd1);
        set_in(u, 1'b0, 16'hDEAD, 16'hBEEF, 16'h1234);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done_w[u]) begin
                lat = k;
                break;
            end
        end
        check({nm, "_done_latency"}, 32'(lat), 32'(2 + mulc));
        @(posedge clk);
        #1;
        check({nm, "_done_fall"}, 32'(done_w[u]), 32'd0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] && busy_w[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_done_overlap u%0d: busy=1 done=1, required not both", i);
            end
            if (done_w[i]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done u%0d: done=1, required no pending result", i);
                end else begin
                    mon_e = sbq.pop_front();
                    check({mon_e.name, "_inst"}, 32'(i), 32'(mon_e.u));
                    check({mon_e.name, "_z"}, 32'(z_w[i]), 32'(mon_e.z));
                    check({mon_e.name, "_x"}, 32'(x_w[i]), 32'(mon_e.x));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, 16'h0, 16'h0, 16'h0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_z_u%0d", u), 32'(z_w[u]), 32'd0);
            check($sformatf("reset_x_u%0d", u), 32'(x_w[u]), 32'd0);
            check($sformatf("reset_done_u%0d", u), 32'(done_w[u]), 32'd0);
            check($sformatf("reset_busy_u%0d", u), 32'(busy_w[u]), 32'd0);
        end
        rst = 1'b1;

        // Basic, wrap and z truncation on the default configuration.
        run_op(0, 1, "basic", 16'd5, 16'd3, 16'd4, 8'd9, 16'd12);
        run_op(0, 1, "wrap", 16'hFFFF, 16'h0002, 16'h0001, 8'h01, 16'hFFFE);
        run_op(0, 1, "ztrunc", 16'h0100, 16'h00AB, 16'h0000, 8'hAB, 16'hFE55);

        // Same stimulus, signed and unsigned compare.
        run_op(1, 1, "signed", 16'hFFFE, 16'h0001, 16'h0005, 8'h03, 16'hFFF7);
        run_op(0, 1, "unsigned", 16'hFFFE, 16'h0001, 16'h0005, 8'hFF, 16'hFFF7);

        // Back-to-back with start held and operands disturbed mid-operation.
        @(negedge clk);
        push_exp(2, 8'h0A, 16'h000C, "b2b_first");
        push_exp(2, 8'h30, 16'h0010, "b2b_second");
        set_in(2, 1'b1, 16'd7, 16'd2, 16'd3);
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_done_E%0d", k), 32'(done_w[2]), 32'((k == 5) || (k == 11)));
            check($sformatf("b2b_busy_E%0d", k), 32'(busy_w[2]),
                  32'(!((k == 5) || (k == 11) || (k == 12))));
            if (k == 0 || k == 6) set_in(2, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            if (k == 3)           set_in(2, 1'b1, 16'h0010, 16'h0020, 16'h0004);
            if (k == 11)          set_in(2, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        end

        // Asynchronous reset while in MUL discards the operation.
        @(negedge clk);
        set_in(2, 1'b1, 16'd1, 16'd1, 16'd1);
        @(posedge clk);
        @(negedge clk);
        set_in(2, 1'b0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_done", 32'(done_w[2]), 32'd0);
        check("rst_mid_busy", 32'(busy_w[2]), 32'd0);
        check("rst_mid_z", 32'(z_w[2]), 32'd0);
        check("rst_mid_x", 32'(x_w[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_queue_empty", 32'(sbq.size()), 32'd0);

        // Recovery after reset.
        run_op(2, 3, "post_rst", 16'd2, 16'd3, 16'd4, 8'd6, 16'd3);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
